// File: rtl/matrix_loader_5x5.sv
// Loads an NxN signed matrix (N = 1..5) row-major into a 5x5 register whose unused
// slots hold identity values, then presents it with a valid/ready handshake.
module matrix_loader_5x5 #(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       size,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    output logic [25*W-1:0]  matrix_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             err
);

    typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

    state_t       state, state_nx;
    logic [2:0]   n_q, row_q, col_q;
    logic [W-1:0] mem [25];
    logic         err_q;
    logic         size_ok, accept, last_col, last_elem;
    logic [4:0]   wr_idx;

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        size_ok   = (size != 3'd0) && (size <= 3'd5);
        accept    = (state == LOAD) && in_valid;
        last_col  = (col_q == n_q - 3'd1);
        last_elem = last_col && (row_q == n_q - 3'd1);
        wr_idx    = {2'b00, row_q} * 5'd5 + {2'b00, col_q};
        state_nx  = state;
        case (state)
            IDLE:    if (start && size_ok)    state_nx = LOAD;
            LOAD:    if (accept && last_elem) state_nx = HOLD;
            HOLD:    if (out_ready)           state_nx = IDLE;
            default:                          state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            n_q   <= '0;
            row_q <= '0;
            col_q <= '0;
            err_q <= 1'b0;
            // NOTE: the matrix store is reset on purpose: matrix_out must read all zeros after reset.
            for (int i = 0; i < 25; i++) mem[i] <= '0;
        end else begin
            err_q <= (state == IDLE) && start && !size_ok;
            if ((state == IDLE) && start && size_ok) begin
                n_q   <= size;
                row_q <= '0;
                col_q <= '0;
                // Diagonal slots sit every sixth index in row-major order.
                for (int i = 0; i < 25; i++) mem[i] <= (i % 6 == 0) ? W'(1) : '0;
            end else if (accept) begin
                mem[wr_idx] <= in_data;
                if (last_col) begin
                    col_q <= '0;
                    row_q <= last_elem ? 3'd0 : row_q + 3'd1;
                end else begin
                    col_q <= col_q + 3'd1;
                end
            end
        end
    end

    // Slot (0,0) lands in the MSBs.
    always_comb begin
        matrix_out = '0;
        for (int i = 0; i < 25; i++) matrix_out[25*W-1-W*i -: W] = mem[i];
    end

    assign in_ready  = (state == LOAD);
    assign out_valid = (state == HOLD);
    assign busy      = (state != IDLE);
    assign err       = err_q;

endmodule
